// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-fetch controller.
package fetch_ctrl_pkg;

  localparam int unsigned INS_W        = 32;
  localparam int unsigned PC_STEP_DFLT = 4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: fetches the word at pc over a req/gnt/rvalid
// handshake, buffers it for decode, and steers writeback's next pc.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = INS_W,
  parameter int unsigned PC_STEP = PC_STEP_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] nextpc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ins,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              fetch_fault,
  output logic [31:0]       fetch_count
);

  fetch_state_t state, state_next;
  logic req, ins_load, ins_clear, count_inc, fault_set;
  logic handoff, misaligned;

  assign handoff    = ins_valid & ins_ready;
  assign misaligned = (pc[1:0] != 2'b00);
  assign imem_addr  = pc;
  assign imem_req   = req & ~rst;

  // State register; reset aborts any in-flight transaction immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_REQ;
    else     state <= state_next;
  end

  // Next state, request, datapath strobes and the pc writeback will latch.
  always_comb begin
    state_next = state;
    nextpc     = pc;
    req        = 1'b0;
    ins_load   = 1'b0;
    ins_clear  = 1'b0;
    count_inc  = 1'b0;
    fault_set  = 1'b0;
    unique case (state)
      S_REQ: begin
        // A fault is sticky: no further requests until reset.
        if (misaligned || fetch_fault) begin
          fault_set = misaligned;
        end else begin
          req = 1'b1;
          if (imem_gnt) state_next = redirect_valid ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid) begin
            state_next = S_REQ;
          end else begin
            ins_load   = 1'b1;
            state_next = S_HOLD;
          end
        end else if (redirect_valid) begin
          state_next = S_DROP;
        end
      end
      S_HOLD: begin
        if (handoff) begin
          count_inc  = 1'b1;
          ins_clear  = 1'b1;
          state_next = S_REQ;
          nextpc     = pc + ADDR_W'(PC_STEP);
        end
        if (redirect_valid) begin
          ins_clear  = 1'b1;
          state_next = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
    // Redirect wins over both hold and the sequential increment.
    if (redirect_valid) nextpc = redirect_target;
  end

  // Instruction buffer, fault flag and handoff counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins         <= '0;
      ins_pc      <= '0;
      ins_valid   <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (ins_load) begin
        ins       <= imem_rdata;
        ins_pc    <= pc;
        ins_valid <= 1'b1;
      end else if (ins_clear) begin
        ins_valid <= 1'b0;
      end
      if (fault_set) fetch_fault <= 1'b1;
      if (count_inc) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl with a writeback pc register closing the loop.
module tb_fetch_ctrl;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  logic        clk, rst;
  logic [31:0] pc, nextpc, imem_addr, imem_rdata, ins, ins_pc, redirect_target, fetch_count;
  logic        imem_req, imem_gnt, imem_rvalid, ins_valid, ins_ready, redirect_valid, fetch_fault;

  exp_t        exp_q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_count = 0;

  fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .nextpc(nextpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Writeback pc register: latches nextpc every clock.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else     pc <= nextpc;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Grant cycle then response cycle; leaves the DUT in S_HOLD.
  task automatic fetch_to_hold(input logic [31:0] data, input logic [31:0] addr);
    imem_gnt = 1'b1;
    next_cycle();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    exp_q.push_back('{data: data, pc: addr});
    next_cycle();
    imem_rvalid = 1'b0;
  endtask

  // Pops the scoreboard on a handoff and compares the buffered word.
  task automatic check_handoff(input string name);
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL %s_sb: handoff with empty scoreboard", name);
    end else begin
      e = exp_q.pop_front();
      if (ins !== e.data || ins_pc !== e.pc || ins_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s_ins: got ins=%h pc=%h v=%b, expected ins=%h pc=%h v=1",
                 name, ins, ins_pc, ins_valid, e.data, e.pc);
      end
    end
    exp_count++;
  endtask

  task automatic test_reset();
    next_cycle(); #1;
    checks++;
    if (imem_req !== 1'b0 || ins_valid !== 1'b0 || ins !== 32'h0 || ins_pc !== 32'h0 ||
        fetch_fault !== 1'b0 || fetch_count !== 32'h0) begin
      errors++;
      $display("FAIL reset: req=%b v=%b ins=%h ins_pc=%h fault=%b cnt=%h, expected all zero",
               imem_req, ins_valid, ins, ins_pc, fetch_fault, fetch_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    imem_gnt = 1'b1; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL seq_req: req=%b addr=%h, expected 1 / 0", imem_req, imem_addr);
    end
    next_cycle();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2001_0005;
    exp_q.push_back('{data: 32'h2001_0005, pc: 32'h0});
    #1;
    checks++;
    if (nextpc !== 32'h0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL seq_wait: nextpc=%h req=%b, expected 0 / 0", nextpc, imem_req);
    end
    next_cycle();
    imem_rvalid = 1'b0; ins_ready = 1'b1; #1;
    check_handoff("seq");
    checks++;
    if (nextpc !== 32'h4) begin
      errors++; $display("FAIL seq_nextpc: got %h expected 00000004", nextpc);
    end
    next_cycle();
    ins_ready = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || fetch_count !== exp_count || ins_valid !== 1'b0) begin
      errors++;
      $display("FAIL seq_next: req=%b addr=%h cnt=%h v=%b, expected 1 / 4 / %h / 0",
               imem_req, imem_addr, fetch_count, ins_valid, exp_count);
    end
  endtask

  task automatic test_backpressure();
    fetch_to_hold(32'h1234_5678, 32'h4);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (ins_valid !== 1'b1 || ins !== 32'h1234_5678 || nextpc !== 32'h4 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v=%b ins=%h nextpc=%h req=%b, expected 1 / 12345678 / 4 / 0",
                 i, ins_valid, ins, nextpc, imem_req);
      end
      next_cycle();
    end
    ins_ready = 1'b1; #1;
    check_handoff("bp");
    checks++;
    if (nextpc !== 32'h8) begin
      errors++; $display("FAIL bp_nextpc: got %h expected 00000008", nextpc);
    end
    next_cycle();
    ins_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1;
    next_cycle();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h100; #1;
    checks++;
    if (nextpc !== 32'h100) begin
      errors++; $display("FAIL rw_nextpc: got %h expected 00000100", nextpc);
    end
    next_cycle();
    redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    checks++;
    if (imem_req !== 1'b0 || ins_valid !== 1'b0) begin
      errors++; $display("FAIL rw_drop: req=%b v=%b, expected 0 / 0", imem_req, ins_valid);
    end
    next_cycle();
    imem_rvalid = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || ins_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_refetch: req=%b addr=%h v=%b, expected 1 / 100 / 0", imem_req, imem_addr, ins_valid);
    end
    // Redirect landing together with the response: data is discarded.
    imem_gnt = 1'b1;
    next_cycle();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    redirect_valid = 1'b1; redirect_target = 32'h200;
    next_cycle();
    imem_rvalid = 1'b0; redirect_valid = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || ins_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_same: req=%b addr=%h v=%b, expected 1 / 200 / 0", imem_req, imem_addr, ins_valid);
    end
  endtask

  task automatic test_hold_redirect();
    fetch_to_hold(32'hCAFE_F00D, 32'h200);
    ins_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40; #1;
    check_handoff("hr");
    checks++;
    if (nextpc !== 32'h40) begin
      errors++; $display("FAIL hr_nextpc: got %h expected 00000040", nextpc);
    end
    next_cycle();
    ins_ready = 1'b0; redirect_valid = 1'b0; #1;
    checks++;
    if (fetch_count !== exp_count || imem_req !== 1'b1 || imem_addr !== 32'h40 || ins_valid !== 1'b0) begin
      errors++;
      $display("FAIL hr_next: cnt=%h req=%b addr=%h v=%b, expected %h / 1 / 40 / 0",
               fetch_count, imem_req, imem_addr, ins_valid, exp_count);
    end
  endtask

  task automatic test_wrap_fault();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    next_cycle();
    redirect_valid = 1'b0;
    fetch_to_hold(32'h0BAD_C0DE, 32'hFFFF_FFFC);
    ins_ready = 1'b1; #1;
    check_handoff("wrap");
    checks++;
    if (nextpc !== 32'h0) begin
      errors++; $display("FAIL wrap_nextpc: got %h expected 00000000", nextpc);
    end
    next_cycle();
    ins_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h102; #1;
    checks++;
    if (nextpc !== 32'h102) begin
      errors++; $display("FAIL fault_redir: got %h expected 00000102", nextpc);
    end
    next_cycle();
    redirect_valid = 1'b0; imem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (imem_req !== 1'b0 || nextpc !== 32'h102 || (i > 0 && fetch_fault !== 1'b1)) begin
        errors++;
        $display("FAIL fault[%0d]: req=%b nextpc=%h fault=%b, expected 0 / 102 / 1",
                 i, imem_req, nextpc, fetch_fault);
      end
      next_cycle();
    end
    imem_gnt = 1'b0;
  endtask

  task automatic test_async_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; exp_count = 0;
    fetch_to_hold(32'h1111_2222, 32'h0);
    ins_ready = 1'b1; #1;
    check_handoff("ar");
    next_cycle();
    ins_ready = 1'b0; imem_gnt = 1'b1;
    next_cycle();
    imem_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (fetch_count !== 32'h0 || ins !== 32'h0 || ins_pc !== 32'h0 || ins_valid !== 1'b0 ||
        imem_req !== 1'b0 || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL ar_async: cnt=%h ins=%h ins_pc=%h v=%b req=%b fault=%b, expected all zero",
               fetch_count, ins, ins_pc, ins_valid, imem_req, fetch_fault);
    end
    next_cycle();
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL ar_req: req=%b addr=%h, expected 1 / 0", imem_req, imem_addr);
    end
    next_cycle();
    imem_rvalid = 1'b0; #1;
    checks++;
    if (ins_valid !== 1'b0 || imem_req !== 1'b1 || ins !== 32'h0) begin
      errors++;
      $display("FAIL ar_late: v=%b req=%b ins=%h, expected 0 / 1 / 0", ins_valid, imem_req, ins);
    end
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    ins_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_hold_redirect();
    test_wrap_fault();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
